// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data port.
//   OP_LOAD / OP_STORE : major opcodes that start a memory access
//   F3_*               : funct3 access-size / signedness encodings
//   lsu_state_e        : access state machine states
//   cnt_width()        : width of a counter that must hold 0..timeout
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_e;

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/lsu_data_port_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   bus_req   : access request, held until bus_ack
//   bus_we    : 1 = write
//   bus_addr  : word-aligned byte address
//   bus_wdata : lane-steered store data
//   bus_be    : byte enables
//   bus_rdata : read data, valid with bus_ack
//   bus_ack   : access complete
//   bus_err   : access failed, qualifies bus_ack
interface lsu_data_port_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             bus_req;
    logic             bus_we;
    logic [WIDTH-1:0] bus_addr;
    logic [WIDTH-1:0] bus_wdata;
    logic [3:0]       bus_be;
    logic [WIDTH-1:0] bus_rdata;
    logic             bus_ack;
    logic             bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_rdata, bus_ack, bus_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit (32-bit, 4 lanes).
//   i_is_store     : current access is a store
//   i_funct3       : size/signedness of the access being issued
//   i_off          : byte offset (address bits [1:0]) of the access being issued
//   i_store_data   : RS2 value
//   o_wdata        : store data replicated onto every lane it may land in
//   o_be           : byte enables (all ones for loads)
//   o_misaligned   : offset not naturally aligned for the access size
//   o_illegal      : funct3 not a valid encoding for this access type
//   i_ld_funct3    : funct3 captured for the outstanding load
//   i_ld_off       : byte offset captured for the outstanding load
//   i_rdata        : raw bus read data
//   o_load_data    : selected and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misaligned,
    output logic        o_illegal,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    // Issue side: legality, byte enables and lane replication.
    always_comb begin
        o_wdata      = '0;
        o_be         = 4'b1111;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_B: begin
                if (i_is_store) begin
                    o_be    = 4'b0001 << i_off;
                    o_wdata = {4{i_store_data[7:0]}};
                end
            end
            F3_H: begin
                o_misaligned = i_off[0];
                if (i_is_store) begin
                    o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
            end
            F3_W: begin
                o_misaligned = (i_off != 2'b00);
                if (i_is_store) begin
                    o_wdata = i_store_data;
                end
            end
            // Unsigned sizes only exist for loads.
            F3_BU: begin
                o_illegal = i_is_store;
            end
            F3_HU: begin
                o_illegal    = i_is_store;
                o_misaligned = i_off[0];
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    // Return side: move the addressed lane down to bit 0, then extend.
    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_load_data = i_rdata;
        case (i_ld_funct3)
            F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_load_data = {24'b0, w_shifted[7:0]};
            F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_load_data = {16'b0, w_shifted[15:0]};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store unit between the ALU and a valid/ack data-memory bus.
// Stalls the single-cycle core while an access is outstanding and hands back
// an extended load result (rd_we pulse) or an abort (fault pulse).
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_opcode        : current instruction opcode
//   i_funct3        : access size / signedness
//   i_mem_addr      : byte address from the ALU
//   i_store_data    : RS2 value
//   io_bus          : data-memory bus (master side)
//   o_stall         : hold PC and register file
//   o_load_data     : extended load result, valid with o_rd_we
//   o_rd_we         : one-cycle write-back pulse
//   o_fault         : one-cycle abort pulse (misaligned, illegal, bus error, timeout)
// Only WIDTH = 32 is supported; the interface must use the same WIDTH.
module lsu_data_port
    import lsu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [6:0]         i_opcode,
    input  logic [2:0]         i_funct3,
    input  logic [WIDTH-1:0]   i_mem_addr,
    input  logic [WIDTH-1:0]   i_store_data,
    lsu_data_port_if.master    io_bus,
    output logic               o_stall,
    output logic [WIDTH-1:0]   o_load_data,
    output logic               o_rd_we,
    output logic               o_fault
);

    localparam int unsigned       CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e       r_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [CW-1:0]    r_cnt;
    logic             r_req;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [3:0]       r_be;
    logic [WIDTH-1:0] r_load_data;
    logic             r_rd_we;
    logic             r_fault;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_mem;
    logic [WIDTH-1:0] w_wdata;
    logic [3:0]       w_be;
    logic             w_misaligned;
    logic             w_illegal;
    logic [WIDTH-1:0] w_load_data;

    assign w_is_load  = (i_opcode == OP_LOAD);
    assign w_is_store = (i_opcode == OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;

    lsu_align u_align (
        .i_is_store   (w_is_store),
        .i_funct3     (i_funct3),
        .i_off        (i_mem_addr[1:0]),
        .i_store_data (i_store_data),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal),
        .i_ld_funct3  (r_funct3),
        .i_ld_off     (r_off),
        .i_rdata      (io_bus.bus_rdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_load_data <= '0;
            r_rd_we     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            // Completion outputs are single-cycle pulses.
            r_rd_we     <= 1'b0;
            r_fault     <= 1'b0;
            r_load_data <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_is_mem) begin
                        r_is_store <= w_is_store;
                        r_funct3   <= i_funct3;
                        r_off      <= i_mem_addr[1:0];
                        r_we       <= w_is_store;
                        r_addr     <= {i_mem_addr[WIDTH-1:2], 2'b00};
                        r_wdata    <= w_wdata;
                        r_be       <= w_be;
                        r_cnt      <= '0;
                        if (w_misaligned || w_illegal) begin
                            r_fault <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (io_bus.bus_ack) begin
                        r_req   <= 1'b0;
                        r_state <= DONE;
                        if (io_bus.bus_err) begin
                            r_fault <= 1'b1;
                        end else if (!r_is_store) begin
                            r_rd_we     <= 1'b1;
                            r_load_data <= w_load_data;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The opcode is still visible here; it has already been served.
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.bus_req   = r_req;
    assign io_bus.bus_we    = r_we;
    assign io_bus.bus_addr  = r_addr;
    assign io_bus.bus_wdata = r_wdata;
    assign io_bus.bus_be    = r_be;

    // Gated by reset so stall is low while reset is held, even with a memory opcode present.
    assign o_stall = i_rst_n & (((r_state == IDLE) & w_is_mem) | (r_state == ACCESS));

    assign o_load_data = r_load_data;
    assign o_rd_we     = r_rd_we;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_lsu_data_port.sv
module tb_lsu_data_port;

    localparam int unsigned TO = 4;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] ALU_OP = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic [31:0] load_data;
    logic        rd_we;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_data_port_if #(.WIDTH(32)) bus_if ();

    lsu_data_port #(
        .WIDTH   (32),
        .TIMEOUT (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_opcode     (opcode),
        .i_funct3     (funct3),
        .i_mem_addr   (mem_addr),
        .i_store_data (store_data),
        .io_bus       (bus_if),
        .o_stall      (stall),
        .o_load_data  (load_data),
        .o_rd_we      (rd_we),
        .o_fault      (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain rules for legality, lanes and extension.
    function automatic bit mdl_legal(input bit st, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'd0: return 1'b1;
            3'd1: return (off % 2) == 0;
            3'd2: return off == 0;
            3'd4: return !st;
            3'd5: return !st && ((off % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] mdl_be(input bit st, input logic [2:0] f3, input logic [1:0] off);
        if (!st) return 4'hF;
        case (f3)
            3'd0: return 4'(1 << off);
            3'd1: return (off == 0) ? 4'h3 : 4'hC;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0: return (sd & 32'hFF) * 32'h0101_0101;
            3'd1: return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> (8 * off);
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
            3'd4: v = sh & 32'hFF;
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
            3'd5: v = sh & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    // One instruction from presentation to retire. delay = ACCESS cycles before ack
    // (delay >= TO means ack is withheld).
    task automatic run_access(input string nm, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sd, input int delay,
                              input bit err, input logic [31:0] rdata);
        bit is_ld;
        bit is_st;
        bit acked;
        bit ok;
        is_ld = (op == LD);
        is_st = (op == ST);
        @(posedge clk); #1;
        opcode = op; funct3 = f3; mem_addr = addr; store_data = sd;
        bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
        @(negedge clk);
        check({nm, ":stall_issue"}, stall, is_ld || is_st);
        check({nm, ":rd_we_idle"}, rd_we, 0);
        check({nm, ":fault_idle"}, fault, 0);
        if (!(is_ld || is_st)) return;
        if (!mdl_legal(is_st, f3, addr[1:0])) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({nm, ":req_bad"}, bus_if.bus_req, 0);
            check({nm, ":stall_bad"}, stall, 0);
            check({nm, ":fault_bad"}, fault, 1);
            check({nm, ":rd_we_bad"}, rd_we, 0);
            check({nm, ":ld_bad"}, load_data, 0);
            return;
        end
        acked = 1'b0;
        for (int n = 0; n < int'(TO); n++) begin
            @(posedge clk); #1;
            acked = (n == delay);
            bus_if.bus_ack   = acked;
            bus_if.bus_err   = acked && err;
            bus_if.bus_rdata = acked ? rdata : $urandom;
            @(negedge clk);
            check({nm, ":req_acc"}, bus_if.bus_req, 1);
            check({nm, ":stall_acc"}, stall, 1);
            if (n == 0) begin
                check({nm, ":addr"}, bus_if.bus_addr, addr & 32'hFFFF_FFFC);
                check({nm, ":we"}, bus_if.bus_we, is_st);
                check({nm, ":be"}, bus_if.bus_be, mdl_be(is_st, f3, addr[1:0]));
                if (is_st) check({nm, ":wdata"}, bus_if.bus_wdata, mdl_wdata(f3, sd));
            end
            if (acked) break;
        end
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
        @(negedge clk);
        ok = (delay < int'(TO)) && !err;
        check({nm, ":stall_done"}, stall, 0);
        check({nm, ":req_done"}, bus_if.bus_req, 0);
        check({nm, ":fault_done"}, fault, !ok);
        check({nm, ":rd_we_done"}, rd_we, ok && is_ld);
        check({nm, ":ld_done"}, load_data, (ok && is_ld) ? mdl_load(f3, addr[1:0], rdata) : 0);
    endtask

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = '0;
        #12;
        check("rst_stall", stall, 0);
        check("rst_req", bus_if.bus_req, 0);
        check("rst_we", bus_if.bus_we, 0);
        check("rst_addr", bus_if.bus_addr, 0);
        check("rst_wdata", bus_if.bus_wdata, 0);
        check("rst_be", bus_if.bus_be, 0);
        check("rst_rd_we", rd_we, 0);
        check("rst_fault", fault, 0);
        check("rst_ld", load_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases.
        run_access("lw",      LD, 3'b010, 32'h100, 0, 0, 0, 32'hDEAD_BEEF);
        run_access("lb",      LD, 3'b000, 32'h103, 0, 0, 0, 32'h80FF_FF7F);
        run_access("lbu",     LD, 3'b100, 32'h103, 0, 0, 0, 32'h80FF_FF7F);
        run_access("lh_hi",   LD, 3'b001, 32'h102, 0, 1, 0, 32'h8001_7FFF);
        run_access("sh",      ST, 3'b001, 32'h102, 32'h0000_ABCD, 0, 0, 0);
        run_access("sb",      ST, 3'b000, 32'h101, 32'h1234_5678, 2, 0, 0);
        run_access("sw_mis",  ST, 3'b010, 32'h101, 32'h1111_2222, 0, 0, 0);
        run_access("st_f011", ST, 3'b011, 32'h100, 32'h1111_2222, 0, 0, 0);
        run_access("sbu_ill", ST, 3'b100, 32'h100, 32'h1111_2222, 0, 0, 0);
        run_access("lw_to",   LD, 3'b010, 32'h100, 0, 99, 0, 32'h0);
        run_access("lw_last", LD, 3'b010, 32'h104, 0, int'(TO) - 1, 0, 32'hCAFE_F00D);
        run_access("lw_err",  LD, 3'b010, 32'h100, 0, 1, 1, 32'h5555_AAAA);
        run_access("alu",     ALU_OP, 3'b010, 32'h100, 0, 0, 0, 0);

        // Reset asserted while an access is outstanding.
        @(posedge clk); #1;
        opcode = LD; funct3 = 3'b010; mem_addr = 32'h200;
        @(posedge clk); #1;
        check("rstmid_req_before", bus_if.bus_req, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_req", bus_if.bus_req, 0);
        check("rstmid_stall", stall, 0);
        check("rstmid_addr", bus_if.bus_addr, 0);
        check("rstmid_be", bus_if.bus_be, 0);
        check("rstmid_rd_we", rd_we, 0);
        check("rstmid_fault", fault, 0);
        opcode = ALU_OP;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_access("lw_after_rst", LD, 3'b010, 32'h300, 0, 0, 0, 32'h0BAD_CAFE);

        // Randomised traffic against the model.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: op = ALU_OP;
                1: op = LD;
                2: op = ST;
                default: op = 7'b1100011;
            endcase
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_access("rnd", op, f3, addr, $urandom, int'($urandom_range(0, 5)),
                       ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
